// File: rtl/freq_monitor_mc.sv
// Multi-channel clock frequency monitor: counts synchronised rising edges of each
// test clock over a shared gate window, scales to Hz and classifies with hysteresis.
module freq_monitor_mc #(
   parameter int NUM_CH      = 2,
   parameter int GATE_CYCLES = 5000000,
   parameter int SCALE       = 10,
   parameter int CNT_W       = 24,
   parameter int TH_HZ       = 1500000,
   parameter int SYNC        = 3
) (
   input  logic                  clk_ref,
   input  logic                  rst_n,
   input  logic [NUM_CH-1:0]     clk_test,
   output logic [32*NUM_CH-1:0]  freq_hz,
   output logic [NUM_CH-1:0]     freq_valid,
   output logic [2*NUM_CH-1:0]   mode,
   output logic [NUM_CH-1:0]     stuck,
   output logic [NUM_CH-1:0]     overflow,
   output logic                  meas_stb
);

   localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
   localparam int SW = $clog2(SCALE + 1);
   localparam int PW = CNT_W + SW;

   localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [1:0]       CLS_STOP  = 2'd0;
   localparam logic [1:0]       CLS_SLOW  = 2'd1;
   localparam logic [1:0]       CLS_FAST  = 2'd2;

   logic [GW-1:0] gate_cnt_r;
   logic          gate_end_s;
   logic          meas_stb_r;

   assign gate_end_s = (gate_cnt_r == GATE_LAST);

   // Shared gate window counter, wraps after GATE_CYCLES cycles
   always_ff @(posedge clk_ref or negedge rst_n) begin
      if (!rst_n) begin
         gate_cnt_r <= GW'(0);
      end else if (gate_end_s) begin
         gate_cnt_r <= GW'(0);
      end else begin
         gate_cnt_r <= gate_cnt_r + GW'(1);
      end
   end

   // Strobe lands in the same cycle the channel outputs take their new values
   always_ff @(posedge clk_ref or negedge rst_n) begin
      if (!rst_n) begin
         meas_stb_r <= 1'b0;
      end else begin
         meas_stb_r <= gate_end_s;
      end
   end

   assign meas_stb = meas_stb_r;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [SYNC-1:0]  sync_r;
      logic             rise_s;
      logic [CNT_W-1:0] cnt_r;
      logic [CNT_W-1:0] cnt_nxt_s;
      logic             sat_r;
      logic             sat_nxt_s;
      logic [PW-1:0]    prod_s;
      logic [63:0]      prod_wide_s;
      logic [31:0]      hz_s;
      logic             hz_sat_s;
      logic [1:0]       raw_s;
      logic [1:0]       prev_raw_r;
      logic [1:0]       mode_r;
      logic [31:0]      freq_r;
      logic             valid_r;
      logic             stuck_r;
      logic             ovf_r;

      // Top two synchroniser stages reading 01 mark one rising edge
      assign rise_s = sync_r[SYNC-2] & ~sync_r[SYNC-1];

      // Synchroniser shift register
      always_ff @(posedge clk_ref or negedge rst_n) begin
         if (!rst_n) begin
            sync_r <= {SYNC{1'b0}};
         end else begin
            sync_r <= {sync_r[SYNC-2:0], clk_test[i]};
         end
      end

      // Count as it would be after this cycle, so a gate-end edge is latched too
      always_comb begin
         cnt_nxt_s = cnt_r;
         sat_nxt_s = sat_r;
         if (rise_s) begin
            if (cnt_r == CNT_MAX) begin
               sat_nxt_s = 1'b1;
            end else begin
               cnt_nxt_s = cnt_r + CNT_W'(1);
            end
         end else begin
            cnt_nxt_s = cnt_r;
            sat_nxt_s = sat_r;
         end
      end

      // Full-precision scale to Hz, clamp to 32 bits, then raw classification
      always_comb begin
         prod_s      = PW'(cnt_nxt_s) * PW'(SCALE);
         prod_wide_s = 64'(prod_s);
         if (prod_wide_s > 64'h0000_0000_FFFF_FFFF) begin
            hz_s     = 32'hFFFF_FFFF;
            hz_sat_s = 1'b1;
         end else begin
            hz_s     = prod_wide_s[31:0];
            hz_sat_s = 1'b0;
         end
         if (cnt_nxt_s == CNT_ZERO) begin
            raw_s = CLS_STOP;
         end else if (hz_s < 32'(TH_HZ)) begin
            raw_s = CLS_SLOW;
         end else begin
            raw_s = CLS_FAST;
         end
      end

      // Per-gate counting; at gate end latch results and restart from zero
      always_ff @(posedge clk_ref or negedge rst_n) begin
         if (!rst_n) begin
            cnt_r      <= CNT_ZERO;
            sat_r      <= 1'b0;
            freq_r     <= 32'd0;
            valid_r    <= 1'b0;
            stuck_r    <= 1'b0;
            ovf_r      <= 1'b0;
            prev_raw_r <= CLS_STOP;
            mode_r     <= CLS_STOP;
         end else if (gate_end_s) begin
            cnt_r      <= CNT_ZERO;
            sat_r      <= 1'b0;
            freq_r     <= hz_s;
            valid_r    <= 1'b1;
            stuck_r    <= (cnt_nxt_s == CNT_ZERO);
            ovf_r      <= sat_nxt_s | hz_sat_s;
            prev_raw_r <= raw_s;
            // Class only moves after two consecutive agreeing gates
            if (raw_s == prev_raw_r) begin
               mode_r <= raw_s;
            end else begin
               mode_r <= mode_r;
            end
         end else begin
            cnt_r <= cnt_nxt_s;
            sat_r <= sat_nxt_s;
         end
      end

      assign freq_hz[32*i +: 32] = freq_r;
      assign freq_valid[i]       = valid_r;
      assign mode[2*i +: 2]      = mode_r;
      assign stuck[i]            = stuck_r;
      assign overflow[i]         = ovf_r;
   end

endmodule

// File: tb/tb_freq_monitor_mc.sv
// Scoreboard bench for freq_monitor_mc: expected output snapshots are queued as
// stimulus is set up and popped when the monitor strobes (or at reset checks).
module tb_freq_monitor_mc;

   logic        clk_ref = 1'b0;
   logic        rst_n   = 1'b0;
   logic [1:0]  clk_main;
   logic [1:0]  clk_sat;

   logic [63:0] freq_hz_m,  freq_hz_s;
   logic [1:0]  valid_m,    valid_s;
   logic [3:0]  mode_m,     mode_s;
   logic [1:0]  stuck_m,    stuck_s;
   logic [1:0]  ovf_m,      ovf_s;
   logic        stb_m,      stb_s;

   int          per      [4];
   int          ph       [4];
   int          last_per [4];
   logic [3:0]  gen = 4'b0000;
   logic        man_en0  = 1'b0;
   logic        man_val0 = 1'b0;

   int          vectors    = 0;
   int          miscompares = 0;
   logic [74:0] exp_q [$];
   logic [74:0] e;
   logic [74:0] obs_main;
   logic [74:0] obs_sat;

   freq_monitor_mc #(.NUM_CH(2), .GATE_CYCLES(1000), .SCALE(50000), .CNT_W(24),
                     .TH_HZ(1500000), .SYNC(3)) dut (
      .clk_ref(clk_ref), .rst_n(rst_n), .clk_test(clk_main),
      .freq_hz(freq_hz_m), .freq_valid(valid_m), .mode(mode_m),
      .stuck(stuck_m), .overflow(ovf_m), .meas_stb(stb_m));

   freq_monitor_mc #(.NUM_CH(2), .GATE_CYCLES(1000), .SCALE(50000), .CNT_W(4),
                     .TH_HZ(1500000), .SYNC(3)) dut4 (
      .clk_ref(clk_ref), .rst_n(rst_n), .clk_test(clk_sat),
      .freq_hz(freq_hz_s), .freq_valid(valid_s), .mode(mode_s),
      .stuck(stuck_s), .overflow(ovf_s), .meas_stb(stb_s));

   always #5 clk_ref = ~clk_ref;

   assign clk_main = {gen[1], man_en0 ? man_val0 : gen[0]};
   assign clk_sat  = gen[3:2];
   assign obs_main = {freq_hz_m, valid_m, mode_m, stuck_m, ovf_m, stb_m};
   assign obs_sat  = {freq_hz_s, valid_s, mode_s, stuck_s, ovf_s, stb_s};

   // Square-wave generators locked to clk_ref; a period change restarts low
   always @(negedge clk_ref) begin
      for (int c = 0; c < 4; c++) begin
         if (!rst_n || per[c] == 0 || per[c] != last_per[c]) ph[c] = 0;
         else ph[c] = (ph[c] + 1) % per[c];
         last_per[c] = per[c];
         gen[c] = (per[c] != 0) && (ph[c] >= per[c] / 2);
      end
   end

   function automatic logic [74:0] mk(input logic [31:0] hz1, input logic [31:0] hz0,
                                      input logic [1:0] v, input logic [3:0] m,
                                      input logic [1:0] s, input logic [1:0] o,
                                      input logic stb);
      return {hz1, hz0, v, m, s, o, stb};
   endfunction

   task wait_strobe(output int n);
      n = 0;
      do begin
         @(negedge clk_ref);
         n++;
      end while (stb_m !== 1'b1 && n < 3000);
      vectors++;
      if (stb_m !== 1'b1) begin
         miscompares++;
         $display("FAIL strobe_timeout: got no meas_stb after %0d cycles, required one within 1000", n);
      end
   endtask

   task test_reset;
      rst_n = 1'b0;
      repeat (3) @(negedge clk_ref);
      exp_q.push_back(mk(32'd0, 32'd0, 2'b00, 4'b0000, 2'b00, 2'b00, 1'b0));
      exp_q.push_back(mk(32'd0, 32'd0, 2'b00, 4'b0000, 2'b00, 2'b00, 1'b0));
      e = exp_q.pop_front(); vectors++;
      if (obs_main !== e) begin miscompares++; $display("FAIL reset_main: got %h required %h", obs_main, e); end
      e = exp_q.pop_front(); vectors++;
      if (obs_sat !== e) begin miscompares++; $display("FAIL reset_sat: got %h required %h", obs_sat, e); end
   endtask

   task test_basic;
      int n;
      per[0] = 50; per[1] = 25; per[2] = 4; per[3] = 0;
      @(negedge clk_ref);
      rst_n = 1'b1;
      exp_q.push_back(mk(32'd2000000, 32'd1000000, 2'b11, 4'b0000, 2'b00, 2'b00, 1'b1));
      exp_q.push_back(mk(32'd2000000, 32'd1000000, 2'b11, 4'b1001, 2'b00, 2'b00, 1'b1));
      wait_strobe(n);
      vectors++;
      if (n !== 1000) begin miscompares++; $display("FAIL first_strobe: got %0d cycles required 1000", n); end
      e = exp_q.pop_front(); vectors++;
      if (obs_main !== e) begin miscompares++; $display("FAIL basic_gate1: got %h required %h", obs_main, e); end
      wait_strobe(n);
      vectors++;
      if (n !== 1000) begin miscompares++; $display("FAIL strobe_spacing: got %0d cycles required 1000", n); end
      e = exp_q.pop_front(); vectors++;
      if (obs_main !== e) begin miscompares++; $display("FAIL basic_gate2: got %h required %h", obs_main, e); end
   endtask

   task test_stuck;
      int n;
      per[0] = 0;
      exp_q.push_back(mk(32'd2000000, 32'd0, 2'b11, 4'b1001, 2'b01, 2'b00, 1'b1));
      exp_q.push_back(mk(32'd2000000, 32'd0, 2'b11, 4'b1001, 2'b01, 2'b00, 1'b0));
      exp_q.push_back(mk(32'd2000000, 32'd0, 2'b11, 4'b1000, 2'b01, 2'b00, 1'b1));
      wait_strobe(n);
      e = exp_q.pop_front(); vectors++;
      if (obs_main !== e) begin miscompares++; $display("FAIL stuck_gate3: got %h required %h", obs_main, e); end
      repeat (500) @(negedge clk_ref);
      e = exp_q.pop_front(); vectors++;
      if (obs_main !== e) begin miscompares++; $display("FAIL hold_midgate: got %h required %h", obs_main, e); end
      wait_strobe(n);
      e = exp_q.pop_front(); vectors++;
      if (obs_main !== e) begin miscompares++; $display("FAIL stuck_gate4: got %h required %h", obs_main, e); end
   endtask

   task test_gate_edge;
      int n;
      man_val0 = 1'b0;
      man_en0  = 1'b1;
      // rising input in cycle 997 is detected in cycle 999 (gate end)
      repeat (997) @(negedge clk_ref);
      man_val0 = 1'b1;
      exp_q.push_back(mk(32'd2000000, 32'd50000, 2'b11, 4'b1000, 2'b00, 2'b00, 1'b1));
      exp_q.push_back(mk(32'd2000000, 32'd0,     2'b11, 4'b1000, 2'b01, 2'b00, 1'b1));
      wait_strobe(n);
      e = exp_q.pop_front(); vectors++;
      if (obs_main !== e) begin miscompares++; $display("FAIL edge_at_gate_end: got %h required %h", obs_main, e); end
      wait_strobe(n);
      e = exp_q.pop_front(); vectors++;
      if (obs_main !== e) begin miscompares++; $display("FAIL edge_next_gate: got %h required %h", obs_main, e); end
   endtask

   task test_overflow;
      int n;
      exp_q.push_back(mk(32'd0, 32'd750000, 2'b11, 4'b0001, 2'b10, 2'b01, 1'b1));
      exp_q.push_back(mk(32'd2000000, 32'd0, 2'b11, 4'b1000, 2'b01, 2'b00, 1'b1));
      wait_strobe(n);
      e = exp_q.pop_front(); vectors++;
      if (obs_sat !== e) begin miscompares++; $display("FAIL overflow_sat: got %h required %h", obs_sat, e); end
      e = exp_q.pop_front(); vectors++;
      if (obs_main !== e) begin miscompares++; $display("FAIL overflow_main: got %h required %h", obs_main, e); end
   endtask

   task test_reset_mid_gate;
      int n;
      repeat (500) @(negedge clk_ref);
      rst_n = 1'b0;
      #1;
      exp_q.push_back(mk(32'd0, 32'd0, 2'b00, 4'b0000, 2'b00, 2'b00, 1'b0));
      exp_q.push_back(mk(32'd0, 32'd0, 2'b00, 4'b0000, 2'b00, 2'b00, 1'b0));
      e = exp_q.pop_front(); vectors++;
      if (obs_main !== e) begin miscompares++; $display("FAIL midreset_main: got %h required %h", obs_main, e); end
      e = exp_q.pop_front(); vectors++;
      if (obs_sat !== e) begin miscompares++; $display("FAIL midreset_sat: got %h required %h", obs_sat, e); end
      man_en0 = 1'b0; man_val0 = 1'b0;
      per[0] = 25; per[1] = 50;
      repeat (3) @(negedge clk_ref);
      rst_n = 1'b1;
      exp_q.push_back(mk(32'd1000000, 32'd2000000, 2'b11, 4'b0000, 2'b00, 2'b00, 1'b1));
      exp_q.push_back(mk(32'd2000000, 32'd2000000, 2'b11, 4'b0010, 2'b00, 2'b00, 1'b1));
      wait_strobe(n);
      vectors++;
      if (n !== 1000) begin miscompares++; $display("FAIL strobe_after_reset: got %0d cycles required 1000", n); end
      e = exp_q.pop_front(); vectors++;
      if (obs_main !== e) begin miscompares++; $display("FAIL after_reset_gate1: got %h required %h", obs_main, e); end
      per[1] = 25;
      wait_strobe(n);
      e = exp_q.pop_front(); vectors++;
      if (obs_main !== e) begin miscompares++; $display("FAIL after_reset_gate2: got %h required %h", obs_main, e); end
   endtask

   task test_alternate;
      int n;
      per[1] = 50;
      exp_q.push_back(mk(32'd1000000, 32'd2000000, 2'b11, 4'b0010, 2'b00, 2'b00, 1'b1));
      wait_strobe(n);
      e = exp_q.pop_front(); vectors++;
      if (obs_main !== e) begin miscompares++; $display("FAIL alternate_slow: got %h required %h", obs_main, e); end
      per[1] = 25;
      exp_q.push_back(mk(32'd2000000, 32'd2000000, 2'b11, 4'b0010, 2'b00, 2'b00, 1'b1));
      wait_strobe(n);
      e = exp_q.pop_front(); vectors++;
      if (obs_main !== e) begin miscompares++; $display("FAIL alternate_fast: got %h required %h", obs_main, e); end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_stuck;
      test_gate_edge;
      test_overflow;
      test_reset_mid_gate;
      test_alternate;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at time %0t, required to have finished", $time);
      $fatal(1);
   end

endmodule

// File: doc/freq_monitor_mc.md
# freq_monitor_mc

Multi-channel, parametrised PHI2/clock frequency monitor. It counts rising edges of NUM_CH asynchronous test clocks over a programmable gate window of `clk_ref` cycles, then scales each count to Hz. It classifies each channel as stopped, slow (C64 class) or fast (C128 class) with two-gate hysteresis, and flags stuck and overflowed channels. It sits beside the bus interface and feeds mode detection and the status registers.

## Interface
- NUM_CH, 2: number of monitored clocks.
- GATE_CYCLES, 5000000: `clk_ref` cycles per gate window (100 ms at 50 MHz). Must be ≥ 2.
- SCALE, 10: multiplier from edge count to Hz. Equals REF_HZ / GATE_CYCLES.
- CNT_W, 24: per-channel edge counter width. The counter saturates.
- TH_HZ, 1500000: slow/fast threshold in Hz.
- SYNC, 3: synchroniser depth, ≥ 3. The top two stages form the edge detector.

Ports:
- clk_ref  in  1  50 MHz reference clock; the only clock.
- rst_n  in  1  asynchronous active-low reset.
- clk_test  in  NUM_CH  asynchronous clocks to measure; bit i is channel i.
- freq_hz  out  32*NUM_CH  measured Hz; channel i is in bits [32i+31:32i].
- freq_valid  out  NUM_CH  channel has completed at least one gate since reset.
- mode  out  2*NUM_CH  debounced class: 0 = stopped, 1 = slow, 2 = fast; 3 is never driven.
- stuck  out  NUM_CH  zero edges in the last gate.
- overflow  out  NUM_CH  counter saturated in the last gate.
- meas_stb  out  1  one-cycle pulse when all outputs take new values.

## Operation
- **Synchroniser.** Each channel has a SYNC-deep synchroniser, reset to 0. A rising edge is the top two stages reading 01.
- **Gate counter.** A single counter, `gate_cnt`, runs 0..GATE_CYCLES-1 and wraps. All channels share the same window.
- **Counting.** Each channel counter increments on each detected rising edge. It saturates at 2^CNT_W-1 and sets a sticky per-gate saturated bit.
- **Gate end (`gate_cnt` == GATE_CYCLES-1):**
  - Latch the count. An edge detected on this same cycle is included in the latched value (count+1, saturated).
  - Clear the counter and the saturated bit for the next gate. The next gate starts from 0; no edge is lost or double-counted.
- **Scaling.** The latched count is multiplied by SCALE at full precision (CNT_W + clog2(SCALE+1) bits). The result saturates to 0xFFFF_FFFF if it exceeds 32 bits.
- **Raw class.** 0 if the count is 0; 1 if the scaled value is < TH_HZ; 2 otherwise.
- **Hysteresis.** Each channel keeps `prev_raw`.
  - `mode` takes the new raw class only when it equals `prev_raw`; otherwise `mode` holds.
  - `prev_raw` always updates to the new raw class. A class change therefore needs two consecutive agreeing gates.
- **Per-channel flags at update:**
  - `stuck` = (count == 0).
  - `overflow` = the saturated bit, or scaled-value saturation.
  - `freq_valid` is set at the first gate end and stays set until reset.
- **Channel independence.** Channels share only `gate_cnt` and `meas_stb`.
- **Measurable range.** Frequencies below REF_HZ/2 are measurable. A test clock needs high and low phases of at least one `clk_ref` period each. Faster inputs alias and are not flagged.

## Timing
- **Reset values.** All outputs are 0: `freq_hz`, `freq_valid`, `mode`, `stuck`, `overflow`, `meas_stb`. All internal counters, `prev_raw` and the synchronisers are also 0.
- **Edge latency.** SYNC `clk_ref` cycles from a `clk_test` edge to counter increment. An edge within SYNC-1 cycles of gate end may count in either gate, consistent with this latency.
- **Update latency.**
  - Gate end is cycle G. All outputs are registered and take new values at the edge ending cycle G, so they are visible in G+1. `meas_stb` is high for exactly cycle G+1.
  - The multiply may be pipelined by at most one extra stage. If it is, all outputs and `meas_stb` move together to G+2.
- **First strobe.** The first `meas_stb` occurs GATE_CYCLES (+1 if pipelined) cycles after reset deasserts.
- **Strobe spacing.** `meas_stb` period is exactly GATE_CYCLES.
- **Reset mid-gate.** Reset immediately clears every state and output, including `freq_valid` and `mode`. The partial gate is discarded. Counting restarts from `gate_cnt` = 0 on release.
- **Hold between strobes.** Outputs hold constant between strobes.

## Test plan
Parameters for all scenarios: GATE_CYCLES=1000, SCALE=50000, NUM_CH=2, CNT_W=24, TH_HZ=1500000.

1. Ch0 square wave with a 50-cycle period; ch1 with a 25-cycle period → after the first strobe, `freq_hz` = 1000000 / 2000000, `freq_valid` = 11, `mode` = 0. After the second strobe, `mode` ch0 = 1 and ch1 = 2.
2. Ch0 held low for a full gate after two 1 MHz gates → `stuck[0]` = 1 and `freq_hz[0]` = 0 at the next strobe. `mode[0]` stays 1, then becomes 0 at the strobe after.
3. Single ch0 edge placed so it is detected exactly on `gate_cnt` = 999 → the latched count includes it. The next gate's count excludes it.
4. CNT_W=4 override, ch0 at a 4-cycle period (250 edges/gate) → count saturates at 15, `overflow[0]` = 1, `freq_hz[0]` = 750000.
5. Assert `rst_n` at `gate_cnt` = 500 for 3 cycles → all outputs are 0 immediately. The next `meas_stb` comes 1000 cycles after release, and `mode` needs two further strobes to reach 2.
6. Ch1 alternating between 1 MHz and 2 MHz every gate → `freq_hz[1]` tracks each gate; `mode[1]` never changes from its initial 0.
